// File: rtl/pca_reg_write_scheduler_pkg.sv
// Shared PCA register map constants, scheduler state encoding and write-entry type
// used by the register write scheduler and its I2C write FIFO.
package pca_reg_write_scheduler_pkg;

    localparam logic [7:0] PCA_LED0_ON_L     = 8'h06;
    localparam logic [7:0] PCA_ALL_LED_ON_L  = 8'hFA;
    localparam logic [7:0] PCA_ALL_LED_OFF_H = 8'hFD;
    localparam logic [7:0] PCA_PRE_SCALE     = 8'hFE;
    localparam int unsigned PCA_LED_STRIDE   = 4;
    localparam int unsigned PCA_LED_COUNT    = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BCAST = 1'b1
    } sched_state_e;

    typedef struct packed {
        logic [7:0] id;
        logic [7:0] value;
    } wr_entry_t;

    function automatic logic is_all_led(input logic [7:0] id);
        return (id >= PCA_ALL_LED_ON_L) && (id <= PCA_ALL_LED_OFF_H);
    endfunction

    // Per-channel register for broadcast step n; max 6+60+3 = 69 so no wrap.
    function automatic logic [7:0] bcast_id(input logic [3:0] n, input logic [1:0] off);
        return PCA_LED0_ON_L + 8'(PCA_LED_STRIDE) * {4'b0000, n} + {6'b000000, off};
    endfunction

endpackage

// File: rtl/pca_write_fifo.sv
// Synchronous FIFO with first-word-fall-through head; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module pca_write_fifo
    import pca_reg_write_scheduler_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      push_i,
    input  wr_entry_t data_i,
    input  logic      pop_i,
    output wr_entry_t data_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wr_entry_t      mem_q [DEPTH];
    wr_entry_t      mem_d [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic           do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop_i & ~empty_o;
        do_push  = push_i & (~full_o | do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/pca_reg_write_scheduler.sv
// Single write-port scheduler for the PCA register file: I2C FIFO first, then the
// internal requester. ALL_LED expansion is built only with PCA_ALL_LED_BROADCAST_EN.
module pca_reg_write_scheduler
    import pca_reg_write_scheduler_pkg::*;
#(
    parameter int unsigned I2C_FIFO_DEPTH = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] i2c_wr_id_i,
    input  logic [7:0] i2c_wr_value_i,
    input  logic       i2c_wr_en_i,
    input  logic       int_req_i,
    input  logic [7:0] int_id_i,
    input  logic [7:0] int_value_i,
    output logic       int_gnt_o,
    input  logic       sleep_i,
    output logic [7:0] reg_wr_id_o,
    output logic [7:0] reg_wr_value_o,
    output logic       reg_wr_en_o,
    output logic       busy_o,
    output logic       overflow_o
);

    logic       en_hist_q, en_hist_d;
    logic       wr_en_q, wr_en_d;
    logic [7:0] wr_id_q, wr_id_d;
    logic [7:0] wr_value_q, wr_value_d;
    logic       gnt_q, gnt_d;
    logic       overflow_q, overflow_d;

    logic       push, pop, idle, sel_valid, discard;
    logic       fifo_full, fifo_empty;
    wr_entry_t  push_data, head, sel;

`ifdef PCA_ALL_LED_BROADCAST_EN
    sched_state_e state_q, state_d;
    logic [3:0]   n_q, n_d;
    logic [1:0]   off_q, off_d;
    logic [7:0]   bval_q, bval_d;

    assign busy_o = (state_q == ST_BCAST) | ~fifo_empty;
`else
    assign busy_o = ~fifo_empty;
`endif

    assign push_data.id    = i2c_wr_id_i;
    assign push_data.value = i2c_wr_value_i;

    pca_write_fifo #(
        .DEPTH (I2C_FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        en_hist_d  = i2c_wr_en_i;
        push       = i2c_wr_en_i & ~en_hist_q;
        pop        = 1'b0;
        gnt_d      = 1'b0;
        wr_en_d    = 1'b0;
        wr_id_d    = wr_id_q;
        wr_value_d = wr_value_q;
        sel_valid  = 1'b0;
        sel        = head;
`ifdef PCA_ALL_LED_BROADCAST_EN
        state_d    = state_q;
        n_d        = n_q;
        off_d      = off_q;
        bval_d     = bval_q;
        idle       = (state_q == ST_IDLE);
`else
        idle       = 1'b1;
`endif
        if (idle) begin
            if (!fifo_empty) begin
                sel_valid = 1'b1;
                pop       = 1'b1;
            end else if (int_req_i) begin
                sel.id    = int_id_i;
                sel.value = int_value_i;
                sel_valid = 1'b1;
                gnt_d     = 1'b1;
            end
        end
        discard    = (sel.id == PCA_PRE_SCALE) && !sleep_i;
        // Drop only when full and nothing leaves the FIFO in the same cycle.
        overflow_d = overflow_q | (push & fifo_full & ~pop);
        if (sel_valid && !discard) begin
`ifdef PCA_ALL_LED_BROADCAST_EN
            if (is_all_led(sel.id)) begin
                off_d   = sel.id[1:0] - 2'(PCA_ALL_LED_ON_L);
                bval_d  = sel.value;
                n_d     = '0;
                state_d = ST_BCAST;
            end else begin
                wr_en_d    = 1'b1;
                wr_id_d    = sel.id;
                wr_value_d = sel.value;
            end
`else
            wr_en_d    = 1'b1;
            wr_id_d    = sel.id;
            wr_value_d = sel.value;
`endif
        end
`ifdef PCA_ALL_LED_BROADCAST_EN
        if (state_q == ST_BCAST) begin
            wr_en_d    = 1'b1;
            wr_id_d    = bcast_id(n_q, off_q);
            wr_value_d = bval_q;
            n_d        = n_q + 4'd1;
            if (n_q == 4'(PCA_LED_COUNT - 1)) begin
                state_d = ST_IDLE;
            end
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_hist_q  <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_id_q    <= '0;
            wr_value_q <= '0;
            gnt_q      <= 1'b0;
            overflow_q <= 1'b0;
`ifdef PCA_ALL_LED_BROADCAST_EN
            state_q    <= ST_IDLE;
            n_q        <= '0;
            off_q      <= '0;
            bval_q     <= '0;
`endif
        end else begin
            en_hist_q  <= en_hist_d;
            wr_en_q    <= wr_en_d;
            wr_id_q    <= wr_id_d;
            wr_value_q <= wr_value_d;
            gnt_q      <= gnt_d;
            overflow_q <= overflow_d;
`ifdef PCA_ALL_LED_BROADCAST_EN
            state_q    <= state_d;
            n_q        <= n_d;
            off_q      <= off_d;
            bval_q     <= bval_d;
`endif
        end
    end

    assign reg_wr_en_o    = wr_en_q;
    assign reg_wr_id_o    = wr_id_q;
    assign reg_wr_value_o = wr_value_q;
    assign int_gnt_o      = gnt_q;
    assign overflow_o     = overflow_q;

endmodule
